// File: rtl/axil_rd_arbiter_pkg.sv
// Shared definitions for the AXI4-lite read arbiter: FSM states, AXI response
// codes and the round-robin pointer advance.
package axil_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Next pointer after serving idx, wrapping so values >= count never appear.
    function automatic int rr_next(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axil_rd_arbiter_if.sv
// AXI4-lite read channel bundle, vectorised over PORTS lanes (lane i at slice i).
interface axil_rd_arbiter_if #(
    parameter int PORTS      = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [PORTS*ADDR_WIDTH-1:0] araddr;
    logic [PORTS*3-1:0]          arprot;
    logic [PORTS-1:0]            arvalid;
    logic [PORTS-1:0]            arready;
    logic [PORTS*DATA_WIDTH-1:0] rdata;
    logic [PORTS*2-1:0]          rresp;
    logic [PORTS-1:0]            rvalid;
    logic [PORTS-1:0]            rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rr_select.sv
// Combinational round-robin selector: first asserted request at or above ptr,
// wrapping from S_COUNT-1 back to 0.
module axil_rr_select #(
    parameter int S_COUNT   = 4,
    parameter int SEL_WIDTH = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]   req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 valid,
    output logic [SEL_WIDTH-1:0] index,
    output logic [S_COUNT-1:0]   grant
);

    int                   idx;
    logic [SEL_WIDTH-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        grant = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            idx = int'(ptr) + i;
            if (idx >= S_COUNT) idx = idx - S_COUNT;
            cand = SEL_WIDTH'(idx);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite read master among S_COUNT requesters,
// with a single outstanding read whose response is steered back to its owner.
import axil_rd_arbiter_pkg::*;

module axil_rd_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_WIDTH  = $clog2(S_COUNT)
) (
    input logic                clk,
    input logic                rst_n,
    axil_rd_arbiter_if.slave   s_axil,
    axil_rd_arbiter_if.master  m_axil
);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [SEL_WIDTH-1:0]   grant_idx;
    logic [SEL_WIDTH-1:0]   rr_ptr;
    logic [ADDR_WIDTH-1:0]  araddr_q;
    logic [2:0]             arprot_q;

    logic                   sel_valid;
    logic [SEL_WIDTH-1:0]   sel_index;
    logic [S_COUNT-1:0]     sel_grant;

    logic [S_COUNT-1:0]     arready;
    logic [S_COUNT-1:0]     rvalid;
    logic                   arvalid;
    logic                   rready;
    logic [DATA_WIDTH-1:0]  rdata_in;

    axil_rr_select #(
        .S_COUNT   (S_COUNT),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_select (
        .req   (s_axil.arvalid),
        .ptr   (rr_ptr),
        .valid (sel_valid),
        .index (sel_index),
        .grant (sel_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            araddr_q  <= '0;
            arprot_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && sel_valid) begin
                grant_idx <= sel_index;
                araddr_q  <= s_axil.araddr[sel_index*ADDR_WIDTH +: ADDR_WIDTH];
                arprot_q  <= s_axil.arprot[sel_index*3 +: 3];
            end
            if (state == ST_RESP && m_axil.rvalid[0] && rready) begin
                rr_ptr <= SEL_WIDTH'(rr_next(int'(grant_idx), S_COUNT));
            end
        end
    end

    // AR is only accepted in IDLE, so the granted port cannot change under a live read.
    always_comb begin
        state_next = state;
        arready    = '0;
        rvalid     = '0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    arready    = sel_grant;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalid = 1'b1;
                if (m_axil.arready[0]) state_next = ST_RESP;
            end
            ST_RESP: begin
                rvalid[grant_idx] = m_axil.rvalid[0];
                rready            = s_axil.rready[grant_idx];
                if (m_axil.rvalid[0] && s_axil.rready[grant_idx]) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rdata_in       = m_axil.rdata;
    assign s_axil.arready = arready;
    assign s_axil.rvalid  = rvalid;
    assign s_axil.rdata   = {S_COUNT{rdata_in}};
    assign s_axil.rresp   = {S_COUNT{m_axil.rresp}};
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = arprot_q;
    assign m_axil.arvalid = arvalid;
    assign m_axil.rready  = rready;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed bench for axil_rd_arbiter: single read, fairness, backpressure,
// error passthrough, reset mid-response and late arrival.
import axil_rd_arbiter_pkg::*;

module tb_axil_rd_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] resp_codes [4];

    always #5 clk = ~clk;

    axil_rd_arbiter_if #(.PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) s_bus ();
    axil_rd_arbiter_if #(.PORTS(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) m_bus ();

    axil_rd_arbiter #(
        .S_COUNT    (4),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axil (s_bus),
        .m_axil (m_bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [2:0] prot);
        s_bus.araddr[port*32 +: 32] = addr;
        s_bus.arprot[port*3 +: 3]   = prot;
        s_bus.arvalid[port]         = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one full read for the expected winner; called one step after a clock edge.
    task automatic serve_read(input int port, input logic [31:0] addr, input logic [2:0] prot,
                              input int ar_delay, input int r_delay, input int rready_delay,
                              input logic [31:0] rd, input logic [1:0] rr,
                              input bit keep, input int late_port);
        logic [3:0] exp_oh;
        int waited;
        int other;
        exp_oh = 4'b0001 << port;
        other  = (port + 1) % 4;
        waited = 0;
        #1;
        while (s_bus.arready == 4'b0 && waited < 20) begin
            cycle();
            #1;
            waited++;
        end
        checkOutput("ar_grant", s_bus.arready, exp_oh);
        checkOutput("ar_one_hot", $countones(s_bus.arready), 1);
        cycle();
        if (!keep) s_bus.arvalid[port] = 1'b0;
        for (int i = 0; i <= ar_delay; i++) begin
            m_bus.arready = (i == ar_delay);
            #1;
            checkOutput("m_arvalid", m_bus.arvalid, 1);
            checkOutput("m_araddr", m_bus.araddr, addr);
            checkOutput("m_arprot", m_bus.arprot, prot);
            checkOutput("s_arready_addr", s_bus.arready, 0);
            cycle();
        end
        m_bus.arready = 1'b0;
        if (late_port >= 0) s_bus.arvalid[late_port] = 1'b1;
        for (int i = 0; i <= r_delay + rready_delay; i++) begin
            m_bus.rvalid       = (i >= r_delay);
            m_bus.rdata        = rd;
            m_bus.rresp        = rr;
            s_bus.rready[port] = (i == r_delay + rready_delay);
            #1;
            checkOutput("s_rvalid", s_bus.rvalid, (i >= r_delay) ? exp_oh : 4'b0);
            checkOutput("m_rready", m_bus.rready, (i == r_delay + rready_delay));
            checkOutput("m_arvalid_resp", m_bus.arvalid, 0);
            checkOutput("s_arready_resp", s_bus.arready, 0);
            if (i >= r_delay) begin
                checkOutput("s_rdata", s_bus.rdata[port*32 +: 32], rd);
                checkOutput("s_rresp", s_bus.rresp[port*2 +: 2], rr);
                checkOutput("s_rdata_bcast", s_bus.rdata[other*32 +: 32], rd);
            end
            cycle();
        end
        m_bus.rvalid = 1'b0;
        s_bus.rready = 4'hF;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resp_codes[0] = RESP_OKAY;
        resp_codes[1] = RESP_EXOKAY;
        resp_codes[2] = RESP_SLVERR;
        resp_codes[3] = RESP_DECERR;
        s_bus.araddr  = '0;
        s_bus.arprot  = '0;
        s_bus.arvalid = '0;
        s_bus.rready  = 4'hF;
        m_bus.arready = 1'b0;
        m_bus.rdata   = '0;
        m_bus.rresp   = '0;
        m_bus.rvalid  = 1'b0;

        // Reset state
        cycle();
        cycle();
        #1;
        checkOutput("rst_m_arvalid", m_bus.arvalid, 0);
        checkOutput("rst_m_rready", m_bus.rready, 0);
        checkOutput("rst_s_rvalid", s_bus.rvalid, 0);
        checkOutput("rst_s_arready", s_bus.arready, 0);
        checkOutput("rst_m_araddr", m_bus.araddr, 0);
        checkOutput("rst_m_arprot", m_bus.arprot, 0);
        rst_n = 1'b1;
        cycle();

        // Single request from port 2, response three cycles later
        applyStimulus(2, 32'h0000_0040, 3'b010);
        serve_read(2, 32'h0000_0040, 3'b010, 0, 3, 0, 32'hDEAD_BEEF, RESP_OKAY, 1'b0, -1);

        // Error passthrough on port 3; pointer then wraps to 0
        applyStimulus(3, 32'h0000_0300, 3'b000);
        serve_read(3, 32'h0000_0300, 3'b000, 1, 0, 0, 32'h0, RESP_SLVERR, 1'b0, -1);

        // Fairness with all ports requesting continuously
        for (int p = 0; p < 4; p++) applyStimulus(p, 32'h1000 + p * 32'h100, 3'(p));
        for (int i = 0; i < 8; i++) begin
            serve_read(i % 4, 32'h1000 + (i % 4) * 32'h100, 3'(i % 4), 0, 0, 0,
                       32'hA000_0000 + 32'(i), resp_codes[i % 4], 1'b1, -1);
        end
        s_bus.arvalid = '0;

        // Backpressure on AR then on R for port 1, with port 2 waiting
        applyStimulus(1, 32'h0000_1111, 3'b101);
        applyStimulus(2, 32'h0000_2222, 3'b011);
        serve_read(1, 32'h0000_1111, 3'b101, 5, 0, 4, 32'h1234_5678, RESP_OKAY, 1'b0, -1);
        serve_read(2, 32'h0000_2222, 3'b011, 0, 0, 0, 32'h8765_4321, RESP_DECERR, 1'b0, -1);

        // Late arrival: port 1 raises its request while port 0 is in RESP
        applyStimulus(0, 32'h0000_0A00, 3'b001);
        serve_read(0, 32'h0000_0A00, 3'b001, 0, 2, 0, 32'hCAFE_0000, RESP_OKAY, 1'b0, 1);
        #1;
        checkOutput("late_grant", s_bus.arready, 4'b0010);
        serve_read(1, 32'h0000_1111, 3'b101, 0, 0, 0, 32'hCAFE_0001, RESP_OKAY, 1'b0, -1);

        // Reset while waiting for the response
        applyStimulus(2, 32'h0000_0200, 3'b001);
        #1;
        checkOutput("rst_pre_grant", s_bus.arready, 4'b0100);
        cycle();
        s_bus.arvalid[2] = 1'b0;
        m_bus.arready    = 1'b1;
        cycle();
        m_bus.arready = 1'b0;
        #1;
        checkOutput("rst_pre_rready", m_bus.rready, 1);
        rst_n        = 1'b0;
        m_bus.rvalid = 1'b1;
        m_bus.rdata  = 32'hBAD0_BAD0;
        cycle();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_m_arvalid", m_bus.arvalid, 0);
        checkOutput("rst_mid_m_rready", m_bus.rready, 0);
        checkOutput("rst_mid_s_rvalid", s_bus.rvalid, 0);
        checkOutput("rst_mid_s_arready", s_bus.arready, 0);
        checkOutput("rst_mid_m_araddr", m_bus.araddr, 0);
        m_bus.rvalid = 1'b0;
        cycle();

        // After reset the pointer restarts at port 0
        applyStimulus(3, 32'h0000_3333, 3'b110);
        applyStimulus(0, 32'h0000_0000, 3'b111);
        serve_read(0, 32'h0000_0000, 3'b111, 0, 1, 0, 32'h0F0F_0F0F, RESP_OKAY, 1'b0, -1);
        serve_read(3, 32'h0000_3333, 3'b110, 0, 0, 0, 32'hF0F0_F0F0, RESP_EXOKAY, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
